// File: rtl/text_writer_if.sv
// ---------------------------------------------------------------------------
// text_writer_if
//   Byte stream into the text writer. Uses a valid/ready handshake: a byte
//   transfers on a rising clock edge where both in_valid and in_ready are high.
//
//   in_data   8  ASCII byte            (master -> slave)
//   in_valid  1  in_data is valid      (master -> slave)
//   in_ready  1  slave accepts a byte  (slave -> master)
// ---------------------------------------------------------------------------
interface text_writer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/text_writer.sv
// ---------------------------------------------------------------------------
// text_writer
//   Write side of the character RAM read by the VGA text pipeline. Consumes
//   ASCII bytes, keeps a text cursor and drives the RAM write port so that
//   printable characters land at cell row*COLS+col. Clears the whole screen
//   to FILL after reset and on form feed (0x0C).
//
// Ports
//   clk         in   system/pixel clock, same clock as the RAM write port
//   rstn        in   asynchronous reset, active-low
//   in_if       slave modport of text_writer_if (in_data/in_valid/in_ready)
//   write_en    out  RAM write strobe, one cycle per cell
//   waddr       out  RAM write address
//   wdata       out  RAM write data (character code)
//   busy        out  clear sequence in progress
//   cursor_col  out  current column, 0..COLS-1
//   cursor_row  out  current row, 0..ROWS-1
//
// Configuration macro
//   TEXT_WRITER_AUTOWRAP_EN  when defined, a printable at the last column
//                            wraps the cursor to the start of the next row;
//                            otherwise the cursor sticks at the last column.
//
// All outputs are registered. ADDR_W must satisfy 2**ADDR_W >= COLS*ROWS.
// ---------------------------------------------------------------------------
module text_writer #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 60,
    parameter int unsigned ADDR_W = 13,
    parameter logic [7:0]  FILL   = 8'h20
) (
    input  logic              clk,
    input  logic              rstn,
    text_writer_if.slave      in_if,
    output logic              write_en,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              busy,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row
);

    localparam int unsigned       Cells       = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LastAddr    = ADDR_W'(Cells - 1);
    localparam logic [ADDR_W-1:0] RowStep     = ADDR_W'(COLS);
    localparam logic [6:0]        LastCol     = 7'(COLS - 1);
    localparam logic [5:0]        LastRow     = 6'(ROWS - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [6:0]        col_q, col_d;
    logic [5:0]        row_q, row_d;
    // row_q*COLS, kept incrementally so the address path needs only an adder
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              write_en_q, write_en_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              printable;
    logic              row_wrap;
    logic [5:0]        row_inc;
    logic [ADDR_W-1:0] row_base_inc;

    assign accept    = in_if.in_valid && in_ready_q;
    assign printable = (in_if.in_data >= 8'h20) && (in_if.in_data <= 8'h7E);

    // Cursor position one row down, wrapping the last row back to the top
    assign row_wrap     = (row_q == LastRow);
    assign row_inc      = row_wrap ? 6'd0 : row_q + 6'd1;
    assign row_base_inc = row_wrap ? '0 : row_base_q + RowStep;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        write_en_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        in_ready_d = 1'b0;

        unique case (state_q)
            StClear: begin
                write_en_d = 1'b1;
                waddr_d    = clr_addr_q;
                wdata_d    = FILL;
                if (clr_addr_q == LastAddr) begin
                    clr_addr_d = '0;
                    state_d    = StIdle;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end

            StIdle: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    if (printable) begin
                        write_en_d = 1'b1;
                        waddr_d    = row_base_q + ADDR_W'(col_q);
                        wdata_d    = in_if.in_data;
                        if (col_q != LastCol) begin
                            col_d = col_q + 7'd1;
                        end else begin
`ifdef TEXT_WRITER_AUTOWRAP_EN
                            col_d      = 7'd0;
                            row_d      = row_inc;
                            row_base_d = row_base_inc;
`else
                            // Sticky last column: further printables overwrite it
                            col_d = col_q;
`endif
                        end
                    end else begin
                        case (in_if.in_data)
                            8'h0D: col_d = 7'd0;
                            8'h0A: begin
                                col_d      = 7'd0;
                                row_d      = row_inc;
                                row_base_d = row_base_inc;
                            end
                            8'h08: begin
                                if (col_q != 7'd0) begin
                                    col_d = col_q - 7'd1;
                                end
                            end
                            8'h0C: begin
                                col_d      = 7'd0;
                                row_d      = 6'd0;
                                row_base_d = '0;
                                clr_addr_d = '0;
                                state_d    = StClear;
                                in_ready_d = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: ;
        endcase

        busy_d = ~in_ready_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            col_q      <= 7'd0;
            row_q      <= 6'd0;
            row_base_q <= '0;
            write_en_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 8'h00;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            write_en_q <= write_en_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign write_en       = write_en_q;
    assign waddr          = waddr_q;
    assign wdata          = wdata_q;
    assign busy           = busy_q;
    assign cursor_col     = col_q;
    assign cursor_row     = row_q;

endmodule

// File: tb/tb_text_writer.sv
// ---------------------------------------------------------------------------
// tb_text_writer
//   Self-checking bench for text_writer. Expected RAM writes are pushed to a
//   queue as bytes are driven and popped as write_en pulses appear; cursor and
//   status outputs are compared against a small behavioural model.
//   Honours TEXT_WRITER_AUTOWRAP_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_text_writer;

    localparam int Cols  = 80;
    localparam int Rows  = 60;
    localparam int Cells = Cols * Rows;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        write_en;
    logic [12:0] waddr;
    logic [7:0]  wdata;
    logic        busy;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;

    text_writer_if tw_if ();

    text_writer dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_if      (tw_if),
        .write_en   (write_en),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [20:0] exp_q[$];
    int          m_col = 0;
    int          m_row = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          wr_last = 0;
    int          wr_prev = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Write monitor: every write_en pulse must match the head of the queue
    always @(negedge clk) begin
        if (rstn && write_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none",
                         waddr, wdata);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check_eq("write", {11'd0, waddr, wdata}, {11'd0, e});
            end
            wr_count++;
            wr_prev = wr_last;
            wr_last = cyc;
        end
    end

    task automatic push_fill();
        for (int i = 0; i < Cells; i++) exp_q.push_back({13'(i), 8'h20});
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({13'(m_row * Cols + m_col), b});
            if (m_col < Cols - 1) begin
                m_col++;
            end else begin
`ifdef TEXT_WRITER_AUTOWRAP_EN
                m_col = 0;
                m_row = (m_row + 1) % Rows;
`endif
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % Rows;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            m_col = 0;
            m_row = 0;
            push_fill();
        end
    endtask

    // Present a byte and hold it until the accepting rising edge
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        tw_if.in_data  = b;
        tw_if.in_valid = 1'b1;
        while (!tw_if.in_ready && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", {31'd0, tw_if.in_ready}, 32'd1);
        model_byte(b);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        tw_if.in_valid = 1'b0;
    endtask

    task automatic check_cursor(input string tag);
        check_eq({tag, "_col"}, {25'd0, cursor_col}, m_col);
        check_eq({tag, "_row"}, {26'd0, cursor_row}, m_row);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!tw_if.in_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {31'd0, tw_if.in_ready}, 32'd1);
    endtask

    task automatic drain(input string tag);
        repeat (3) @(negedge clk);
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_we"}, {31'd0, write_en}, 32'd0);
        check_eq({tag, "_waddr"}, {19'd0, waddr}, 32'd0);
        check_eq({tag, "_wdata"}, {24'd0, wdata}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, tw_if.in_ready}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check_eq({tag, "_col"}, {25'd0, cursor_col}, 32'd0);
        check_eq({tag, "_row"}, {26'd0, cursor_row}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int n;
        string hello;
        tw_if.in_data  = 8'h00;
        tw_if.in_valid = 1'b0;

        // Reset and power-on clear
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        push_fill();
        wr_count = 0;
        rstn = 1'b1;
        wait_ready("clr_done");
        check_eq("clr_writes", wr_count, Cells);
        check_eq("clr_busy", {31'd0, busy}, 32'd0);
        drain("clr_drain");

        // Back-to-back printables
        send_byte(8'h41);
        send_byte(8'h42);
        idle();
        drain("ab_drain");
        check_cursor("ab");
        check_eq("ab_col_abs", {25'd0, cursor_col}, 32'd2);
        check_eq("ab_consec", wr_last - wr_prev, 1);

        // CR/LF handling, then a write at (0,4)
        send_byte(8'h0D);
        for (int i = 0; i < 3; i++) send_byte(8'h0A);
        hello = "hello";
        for (int i = 0; i < hello.len(); i++) send_byte(hello[i]);
        idle();
        drain("hello_drain");
        check_cursor("at53");
        snap = wr_count;
        send_byte(8'h0D);
        send_byte(8'h0A);
        idle();
        drain("crlf_drain");
        check_eq("crlf_nowrite", wr_count, snap);
        check_cursor("crlf");
        check_eq("crlf_row_abs", {26'd0, cursor_row}, 32'd4);
        send_byte(8'h5A);
        idle();
        drain("z_drain");
        check_eq("z_addr", {19'd0, waddr}, 32'd320);
        check_eq("z_data", {24'd0, wdata}, 32'h5A);

        // Bottom-right corner
        send_byte(8'h0D);
        for (int i = 0; i < 55; i++) send_byte(8'h0A);
        for (int i = 0; i < 79; i++) send_byte(8'h20);
        idle();
        drain("corner_drain");
        check_cursor("corner");
        send_byte(8'h51);
        idle();
        drain("q_drain");
        check_eq("q_addr", {19'd0, waddr}, 32'd4799);
        check_cursor("after_q");
`ifdef TEXT_WRITER_AUTOWRAP_EN
        check_eq("q_wrap_col", {25'd0, cursor_col}, 32'd0);
        check_eq("q_wrap_row", {26'd0, cursor_row}, 32'd0);
`else
        check_eq("q_stick_col", {25'd0, cursor_col}, 32'd79);
        check_eq("q_stick_row", {26'd0, cursor_row}, 32'd59);
        send_byte(8'h52);
        idle();
        drain("r_drain");
        check_eq("r_addr", {19'd0, waddr}, 32'd4799);
        check_eq("r_data", {24'd0, wdata}, 32'h52);
        check_cursor("after_r");
`endif

        // Backspace, ignored bytes, form feed
        send_byte(8'h0D);
        send_byte(8'h08);
        idle();
        check_cursor("bs_col0");
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        send_byte(8'h08);
        idle();
        drain("abc_drain");
        check_cursor("bs_col3");
        snap = wr_count;
        send_byte(8'h01);
        send_byte(8'h7F);
        send_byte(8'h1B);
        idle();
        drain("ign_drain");
        check_eq("ign_nowrite", wr_count, snap);
        check_cursor("ign");
        snap = wr_count;
        send_byte(8'h0C);
        idle();
        check_eq("ff_ready_low", {31'd0, tw_if.in_ready}, 32'd0);
        check_eq("ff_busy", {31'd0, busy}, 32'd1);
        wait_ready("ff_done");
        check_eq("ff_writes", wr_count - snap, Cells);
        check_eq("ff_busy_done", {31'd0, busy}, 32'd0);
        check_cursor("ff");
        drain("ff_drain");

        // Reset in the middle of a clear
        send_byte(8'h0C);
        idle();
        n = 0;
        while (!(write_en && waddr == 13'd1000) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_reached", {19'd0, waddr}, 32'd1000);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        exp_q.delete();
        push_fill();
        m_col = 0;
        m_row = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_ready("mid_clr_done");
        drain("mid_drain");
        send_byte(8'h58);
        idle();
        drain("x_drain");
        check_eq("x_addr", {19'd0, waddr}, 32'd0);
        check_cursor("x");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
